fifo_sync_prog: RTL and testbench

//  Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.

---
 rtl/fifo_sync_prog.sv | 155 +++++++++++++++
 tb/tb_fifo_sync_prog.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// fifo_sync_prog
//   Single-clock FIFO with arbitrary (non power-of-2) depth, programmable
//   almost-full / almost-empty levels, synchronous flush and a selectable
//   read mode: registered read (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Parameters
//   DATA_WIDTH  word width (>=1)
//   FIFO_DEPTH  number of entries (>=2, any value)
//   AF_LEVEL    almostfull when count >= AF_LEVEL and not full  (1..FIFO_DEPTH-1)
//   AE_LEVEL    almostempty when count <= AE_LEVEL and not empty (1..FIFO_DEPTH-1)
//   FWFT        0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   flush        synchronous clear of contents, overrides wr_en/rd_en
//   wr_en        write request, data_in is the word written
//   rd_en        read request (FWFT: pops the word currently shown)
//   data_out     read data
//   rd_valid     data_out holds a freshly popped (FWFT=0) or shown (FWFT=1) word
//   wr_ack       previous-cycle write was accepted
//   overflow     previous-cycle write was rejected because the FIFO was full
//   underflow    previous-cycle read was rejected because the FIFO was empty
//   full/almostfull/empty/almostempty  occupancy flags derived from count
//   count        current occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  wr_en,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  input  logic                                  rd_en,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  rd_valid,
  output logic                                  wr_ack,
  output logic                                  overflow,
  output logic                                  underflow,
  output logic                                  full,
  output logic                                  almostfull,
  output logic                                  empty,
  output logic                                  almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam ptr_t LAST_PTR = ptr_t'(FIFO_DEPTH - 1);
  localparam cnt_t DEPTH_C  = cnt_t'(FIFO_DEPTH);
  localparam cnt_t AF_C     = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_C     = cnt_t'(AE_LEVEL);

  word_t mem [FIFO_DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  logic  do_wr;
  logic  do_rd;

  // Depth need not be a power of two, so wrap on an explicit compare rather
  // than relying on natural pointer overflow.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  // Status flags: pure functions of count. The "and not full/empty" terms keep
  // each almost flag exclusive with its hard counterpart.
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C) && !full;
  assign almostempty = (count <= AE_C) && !empty;

  // A write against a full FIFO is rejected even when a read frees a slot in
  // the same cycle; flush overrides both requests.
  assign do_wr = wr_en && !full  && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // NOTE: the storage array is deliberately left without a reset: pointers and
  // count alone decide which entries are valid, and an unreset array can map
  // onto RAM. The !rst term stops a write landing while reset is held.
  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= do_wr;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown combinationally; zero while empty so the output
      // never exposes stale storage and matches its reset value.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      word_t rd_data_q;
      logic  rd_valid_q;

      // data_out holds its last popped word; rd_valid pulses per accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= do_rd;
          if (do_rd) rd_data_q <= mem[rd_ptr];
        end
      end

      assign data_out = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_prog
//   Three FIFO instances share one stimulus stream:
//     d0: depth 8, AF 7, AE 1, registered read
//     d1: depth 5, AF 3, AE 2, registered read (non power-of-2 wrap)
//     d2: depth 8, AF 5, AE 2, first-word-fall-through
//   Each instance has a reference model kept as a plain ordered list of words.
//   The stimulus task updates the models at the clock edge and pushes every
//   popped word into a per-instance scoreboard queue; a monitor on the falling
//   edge compares all outputs and pops the scoreboard when rd_valid is seen.
// -----------------------------------------------------------------------------
module tb_fifo_sync_prog;

  localparam int NDUT = 3;
  localparam int DEP  [NDUT] = '{8, 5, 8};
  localparam int AFL  [NDUT] = '{7, 3, 5};
  localparam int AEL  [NDUT] = '{1, 2, 2};
  localparam int ISFW [NDUT] = '{0, 0, 1};

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_in;

  wire [NDUT-1:0]       full_v, af_v, empty_v, ae_v, ack_v, ovf_v, udf_v, rv_v;
  wire [NDUT-1:0][15:0] dout_v;
  wire [3:0]            cnt0;
  wire [2:0]            cnt1;
  wire [3:0]            cnt2;

  fifo_sync_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_v[0]), .rd_valid(rv_v[0]), .wr_ack(ack_v[0]), .overflow(ovf_v[0]),
    .underflow(udf_v[0]), .full(full_v[0]), .almostfull(af_v[0]), .empty(empty_v[0]),
    .almostempty(ae_v[0]), .count(cnt0)
  );

  fifo_sync_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_v[1]), .rd_valid(rv_v[1]), .wr_ack(ack_v[1]), .overflow(ovf_v[1]),
    .underflow(udf_v[1]), .full(full_v[1]), .almostfull(af_v[1]), .empty(empty_v[1]),
    .almostempty(ae_v[1]), .count(cnt1)
  );

  fifo_sync_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(5), .AE_LEVEL(2), .FWFT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout_v[2]), .rd_valid(rv_v[2]), .wr_ack(ack_v[2]), .overflow(ovf_v[2]),
    .underflow(udf_v[2]), .full(full_v[2]), .almostfull(af_v[2]), .empty(empty_v[2]),
    .almostempty(ae_v[2]), .count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int          mlen  [NDUT] = '{0, 0, 0};
  logic [15:0] mq    [NDUT][8];
  bit          e_ack [NDUT] = '{0, 0, 0};
  bit          e_ovf [NDUT] = '{0, 0, 0};
  bit          e_udf [NDUT] = '{0, 0, 0};
  bit          e_rv  [NDUT] = '{0, 0, 0};
  logic [15:0] e_dout[NDUT] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] sb_q0 [$];
  logic [15:0] sb_q1 [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL d%0d.%s: got 0x%0h, expected 0x%0h at %0t", k, name, act, exp, $time);
    end
  endtask

  function automatic int dut_count(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++) begin
      mlen[k]   = 0;
      e_ack[k]  = 0;
      e_ovf[k]  = 0;
      e_udf[k]  = 0;
      e_rv[k]   = 0;
      e_dout[k] = 16'h0;
    end
    sb_q0.delete();
    sb_q1.delete();
  endtask

  // One clock edge of the behavioural FIFO: ordered list, read from the front,
  // append at the back.
  task automatic model_step(input bit f, input bit w, input bit r, input logic [15:0] d);
    for (int k = 0; k < NDUT; k++) begin
      bit          was_full;
      bit          was_empty;
      bit          rd_ok;
      bit          wr_ok;
      logic [15:0] word;
      if (f) begin
        mlen[k]  = 0;
        e_ack[k] = 0;
        e_ovf[k] = 0;
        e_udf[k] = 0;
        e_rv[k]  = 0;
      end else begin
        was_full  = (mlen[k] == DEP[k]);
        was_empty = (mlen[k] == 0);
        rd_ok     = r && !was_empty;
        wr_ok     = w && !was_full;
        e_ack[k]  = wr_ok;
        e_ovf[k]  = w && was_full;
        e_udf[k]  = r && was_empty;
        e_rv[k]   = rd_ok;
        if (rd_ok) begin
          word = mq[k][0];
          for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
          mlen[k]--;
          e_dout[k] = word;
          if (k == 0) sb_q0.push_back(word);
          else if (k == 1) sb_q1.push_back(word);
        end
        if (wr_ok) begin
          mq[k][mlen[k]] = d;
          mlen[k]++;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      int          n;
      logic [15:0] exp_word;
      n = mlen[k];
      check(k, "count",       dut_count(k), n);
      check(k, "full",        full_v[k],    n == DEP[k]);
      check(k, "empty",       empty_v[k],   n == 0);
      check(k, "almostfull",  af_v[k],      (n >= AFL[k]) && (n != DEP[k]));
      check(k, "almostempty", ae_v[k],      (n <= AEL[k]) && (n != 0));
      check(k, "wr_ack",      ack_v[k],     e_ack[k]);
      check(k, "overflow",    ovf_v[k],     e_ovf[k]);
      check(k, "underflow",   udf_v[k],     e_udf[k]);
      if (ISFW[k] != 0) begin
        check(k, "rd_valid", rv_v[k], n != 0);
        if (n != 0) check(k, "data_head", dout_v[k], mq[k][0]);
      end else begin
        check(k, "rd_valid", rv_v[k], e_rv[k]);
        if (rv_v[k]) begin
          if (k == 0 && sb_q0.size() > 0) begin
            exp_word = sb_q0.pop_front();
            check(k, "data_pop", dout_v[k], exp_word);
          end else if (k == 1 && sb_q1.size() > 0) begin
            exp_word = sb_q1.pop_front();
            check(k, "data_pop", dout_v[k], exp_word);
          end else begin
            check(k, "sb_entry", (k == 0) ? sb_q0.size() : sb_q1.size(), 1);
          end
        end else begin
          check(k, "data_hold", dout_v[k], e_dout[k]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cycle(input bit f, input bit w, input bit r, input logic [15:0] d);
    @(negedge clk);
    #1;
    flush   = f;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    model_step(f, w, r, d);
  endtask

  // Assert reset between edges while a burst is still driving wr_en: every
  // output must drop at once, without waiting for a clock.
  task automatic reset_midcycle();
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check(k, "rst_count",       dut_count(k), 0);
      check(k, "rst_empty",       empty_v[k],   1);
      check(k, "rst_full",        full_v[k],    0);
      check(k, "rst_almostfull",  af_v[k],      0);
      check(k, "rst_almostempty", ae_v[k],      0);
      check(k, "rst_wr_ack",      ack_v[k],     0);
      check(k, "rst_overflow",    ovf_v[k],     0);
      check(k, "rst_underflow",   udf_v[k],     0);
      check(k, "rst_rd_valid",    rv_v[k],      0);
      check(k, "rst_data_out",    dout_v[k],    0);
    end
    model_clear();
    @(negedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit          fill;
    logic [15:0] rnd;
    rst     = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 16'h0;
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Fill 1..8, then a ninth write into the full FIFO.
    for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i));
    // Drain, ninth read underflows.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);

    // Simultaneous request while full, then while empty.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0010 + 16'(i));
    cycle(1'b0, 1'b1, 1'b1, 16'h0055);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0066);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);

    // Interleaved traffic to walk the pointers around the depth-5 wrap.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0200 + 16'(i));
      cycle(1'b0, 1'b0, 1'b1, 16'h0);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 16'h0300 + 16'(i));

    // Flush with requests pending, then FWFT write into an empty FIFO.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0400 + 16'(i));
    cycle(1'b1, 1'b1, 1'b1, 16'h0777);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'hABCD);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);

    // Randomised traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 600; i++) begin
      fill = ((i / 40) % 2) == 0;
      rnd  = 16'($urandom);
      cycle($urandom_range(63, 0) == 0,
            $urandom_range(3, 0) < (fill ? 3 : 1),
            $urandom_range(3, 0) < (fill ? 1 : 3),
            rnd);
    end

    // Reset in the middle of a write burst, then confirm normal operation.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0500 + 16'(i));
    reset_midcycle();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0600 + 16'(i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
